// File: rtl/cache_fill_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cache_fill_controller
// Purpose  : Miss-handling sequencer for the memory port shared by the I- and
//            D-caches. On a miss it picks one requester (I-cache wins ties)
//            and streams the whole aligned block from pipelined memory, one
//            read address per cycle. Each returned word is written into the
//            cache data array, and the tag is written along with the last word.
// Ports    : clk, rst (async, active-high)
//            I_miss/D_miss, I_addr/D_addr     - miss requests and addresses
//            memory_data_valid                - in-order read data strobe
//            fsm_busy, mem_en, memory_address - fill status and read issue
//            write_data_array, write_tag_array, Word_Num - cache write controls
//            serving_I, fill_done             - requester select, done pulse
// Revision : 1.0 - initial release
// ============================================================================
module cache_fill_controller #(
    parameter int ADDR_W     = 16,
    parameter int WORD_IDX_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  I_miss,
    input  logic                  D_miss,
    input  logic [ADDR_W-1:0]     I_addr,
    input  logic [ADDR_W-1:0]     D_addr,
    input  logic                  memory_data_valid,
    output logic                  fsm_busy,
    output logic                  mem_en,
    output logic [ADDR_W-1:0]     memory_address,
    output logic                  write_data_array,
    output logic                  write_tag_array,
    output logic [WORD_IDX_W-1:0] Word_Num,
    output logic                  serving_I,
    output logic                  fill_done
);

    // Block offset covers WORD_IDX_W word bits plus the byte-in-word bit.
    localparam int OFF_W = WORD_IDX_W + 1;

    localparam logic [WORD_IDX_W:0]   c_issue_one = {{WORD_IDX_W{1'b0}}, 1'b1};
    localparam logic [WORD_IDX_W-1:0] c_recv_one  = {{(WORD_IDX_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_W-1:0]     r_base;
    logic                  r_serving_i;
    logic [WORD_IDX_W:0]   r_issue_cnt;
    logic [WORD_IDX_W-1:0] r_recv_cnt;

    logic                  w_in_fill;
    logic                  w_issue;
    logic                  w_write;
    logic                  w_last;
    logic [ADDR_W-1:0]     w_sel_base;
    logic [ADDR_W-1:0]     w_offset;

    assign w_in_fill  = (r_state == S_FILL);
    // issue_cnt < BLOCK_WORDS exactly when its top bit is still clear.
    assign w_issue    = w_in_fill && !r_issue_cnt[WORD_IDX_W];
    assign w_write    = w_in_fill && memory_data_valid;
    assign w_last     = w_write && (r_recv_cnt == '1);
    assign w_sel_base = I_miss ? {I_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}}
                               : {D_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_offset   = {{(ADDR_W-OFF_W){1'b0}}, r_issue_cnt[WORD_IDX_W-1:0], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_serving_i <= 1'b0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (I_miss || D_miss) begin
                        r_state     <= S_FILL;
                        r_serving_i <= I_miss;
                        r_base      <= w_sel_base;
                        r_issue_cnt <= '0;
                        r_recv_cnt  <= '0;
                    end
                end
                S_FILL: begin
                    if (w_issue) begin
                        r_issue_cnt <= r_issue_cnt + c_issue_one;
                    end
                    if (w_write) begin
                        r_recv_cnt <= r_recv_cnt + c_recv_one;
                    end
                    if (w_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Misses are ignored here; a pending one is taken from IDLE.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state, so an asynchronous reset
    // drives them all to zero immediately. Data/tag writes follow the valid
    // strobe combinationally in the same cycle.
    assign fsm_busy         = w_in_fill;
    assign fill_done        = (r_state == S_DONE);
    assign mem_en           = w_issue;
    assign memory_address   = w_issue ? (r_base + w_offset) : '0;
    assign write_data_array = w_write;
    assign write_tag_array  = w_last;
    assign Word_Num         = w_write ? r_recv_cnt : '0;
    assign serving_I        = r_serving_i;

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cache_fill_controller
// Purpose  : Directed self-checking bench for cache_fill_controller. A
//            4-cycle in-order memory model answers every issued read; expected
//            addresses, word indices and requester are queued when a miss is
//            raised and popped as the DUT issues reads and writes words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_fill_controller;

    localparam int ADDR_W     = 16;
    localparam int WORD_IDX_W = 3;
    localparam int LAT        = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  I_miss, D_miss;
    logic [ADDR_W-1:0]     I_addr, D_addr;
    logic                  memory_data_valid;
    logic                  fsm_busy, mem_en, write_data_array, write_tag_array;
    logic [ADDR_W-1:0]     memory_address;
    logic [WORD_IDX_W-1:0] Word_Num;
    logic                  serving_I, fill_done;

    cache_fill_controller #(.ADDR_W(ADDR_W), .WORD_IDX_W(WORD_IDX_W)) dut (
        .clk(clk), .rst(rst),
        .I_miss(I_miss), .D_miss(D_miss), .I_addr(I_addr), .D_addr(D_addr),
        .memory_data_valid(memory_data_valid),
        .fsm_busy(fsm_busy), .mem_en(mem_en), .memory_address(memory_address),
        .write_data_array(write_data_array), .write_tag_array(write_tag_array),
        .Word_Num(Word_Num), .serving_I(serving_I), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // scoreboard queues
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic              exp_srv_q[$];
    int                exp_word_q[$];
    int                ret_q[$];

    // memory model / stimulus controls
    logic mv;
    logic force_valid = 1'b0;
    logic gap_en      = 1'b0;
    int   ret_idx     = 0;
    int   gap_hold    = 0;

    // observed event bookkeeping
    int first_issue, last_issue, first_wr, tag_cyc, done_cyc;
    int done_cnt = 0;
    int wr_cnt   = 0;
    int c0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        first_issue = -1; last_issue = -1; first_wr = -1;
        tag_cyc = -1; done_cyc = -1; ret_idx = 0; gap_hold = 0;
    endtask

    task automatic flush();
        exp_addr_q.delete(); exp_srv_q.delete(); exp_word_q.delete(); ret_q.delete();
    endtask

    task automatic expect_fill(input logic [ADDR_W-1:0] base, input logic srv);
        for (int i = 0; i < 8; i++) begin
            exp_addr_q.push_back(base + ADDR_W'(2 * i));
            exp_srv_q.push_back(srv);
            exp_word_q.push_back(i);
        end
    endtask

    task automatic check_outputs();
        if (fsm_busy !== 1'b1) begin
            chk("idle_mem_en", {31'd0, mem_en}, 32'd0);
            chk("idle_addr", {16'd0, memory_address}, 32'd0);
            chk("idle_wr_data", {31'd0, write_data_array}, 32'd0);
            chk("idle_wr_tag", {31'd0, write_tag_array}, 32'd0);
            chk("idle_word", {29'd0, Word_Num}, 32'd0);
        end else begin
            chk("wr_follows_valid", {31'd0, write_data_array}, {31'd0, memory_data_valid});
        end
        if (mem_en === 1'b1) begin
            chk("issue_expected", {31'd0, exp_addr_q.size() != 0}, 32'd1);
            if (exp_addr_q.size() != 0) begin
                chk("mem_addr", {16'd0, memory_address}, {16'd0, exp_addr_q.pop_front()});
                chk("serving_I", {31'd0, serving_I}, {31'd0, exp_srv_q.pop_front()});
            end
            ret_q.push_back(cyc + LAT);
            if (first_issue < 0) first_issue = cyc;
            last_issue = cyc;
        end
        if (write_data_array === 1'b1) begin
            wr_cnt++;
            chk("write_expected", {31'd0, exp_word_q.size() != 0}, 32'd1);
            if (exp_word_q.size() != 0) begin
                int ew;
                ew = exp_word_q.pop_front();
                chk("word_num", {29'd0, Word_Num}, ew);
                chk("tag_on_last", {31'd0, write_tag_array}, {31'd0, ew == 7});
            end
            if (first_wr < 0) first_wr = cyc;
            if (write_tag_array === 1'b1) begin
                tag_cyc = cyc;
                // the cache drops its miss once the tag is written
                if (serving_I === 1'b1) I_miss = 1'b0;
                else D_miss = 1'b0;
            end
        end
        if (fill_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_after_tag", cyc - 1, tag_cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        mv = 1'b0;
        if (ret_q.size() > 0 && ret_q[0] <= cyc) begin
            if (gap_en && (ret_idx == 2 || ret_idx == 5) && gap_hold < 2) begin
                gap_hold++;
            end else begin
                mv = 1'b1;
                void'(ret_q.pop_front());
                ret_idx++;
                gap_hold = 0;
            end
        end
        memory_data_valid = mv | force_valid;
        #3;
        check_outputs();
    endtask

    task automatic run_fill(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk("fill_completed", done_cnt, target);
        chk("addr_q_drained", exp_addr_q.size(), 32'd0);
        chk("word_q_drained", exp_word_q.size(), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, fsm_busy}, 32'd0);
        chk({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
        chk({tag, "_addr"}, {16'd0, memory_address}, 32'd0);
        chk({tag, "_wr_data"}, {31'd0, write_data_array}, 32'd0);
        chk({tag, "_wr_tag"}, {31'd0, write_tag_array}, 32'd0);
        chk({tag, "_word"}, {29'd0, Word_Num}, 32'd0);
        chk({tag, "_srv"}, {31'd0, serving_I}, 32'd0);
        chk({tag, "_done"}, {31'd0, fill_done}, 32'd0);
    endtask

    initial begin
        int wr_before;
        rst = 1'b1; I_miss = 1'b0; D_miss = 1'b0;
        I_addr = '0; D_addr = '0; memory_data_valid = 1'b0;
        clear_stats();

        // Reset state
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Test 1: async reset mid-fill with both misses high
        I_addr = 16'h1236; D_addr = 16'h0042;
        I_miss = 1'b1; D_miss = 1'b1;
        expect_fill(16'h1230, 1'b1);
        tick(); tick(); tick();
        chk("t1_busy_before_rst", {31'd0, fsm_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("t1_async_rst");
        tick(); tick();
        chk("t1_held_idle", {31'd0, fsm_busy}, 32'd0);
        I_miss = 1'b0; D_miss = 1'b0;
        flush(); clear_stats();
        tick();
        rst = 1'b0;
        tick();

        // Test 2: single I miss, nominal timing
        clear_stats();
        expect_fill(16'h1230, 1'b1);
        I_addr = 16'h1236; I_miss = 1'b1;
        c0 = cyc;
        run_fill(done_cnt + 1, 40);
        chk("t2_first_issue", first_issue - c0, 32'd1);
        chk("t2_last_issue", last_issue - c0, 32'd8);
        chk("t2_first_write", first_wr - c0, 32'd5);
        chk("t2_tag", tag_cyc - c0, 32'd12);
        chk("t2_done", done_cyc - c0, 32'd13);
        tick();
        chk("t2_idle_at_14", {30'd0, fsm_busy, fill_done}, 32'd0);

        // Test 3: simultaneous misses, I first then D
        clear_stats();
        expect_fill(16'h1230, 1'b1);
        expect_fill(16'h0040, 1'b0);
        I_addr = 16'h1236; D_addr = 16'h0042;
        I_miss = 1'b1; D_miss = 1'b1;
        run_fill(done_cnt + 2, 80);
        tick(); tick();

        // Test 4: valid gaps on 3rd and 6th returns
        clear_stats();
        gap_en = 1'b1;
        expect_fill(16'h2000, 1'b1);
        I_addr = 16'h200E; I_miss = 1'b1;
        run_fill(done_cnt + 1, 60);
        gap_en = 1'b0;
        tick(); tick(); tick();

        // Test 5: reset at cycle 7 of a fill, stale valids afterwards
        clear_stats();
        expect_fill(16'h3450, 1'b0);
        D_addr = 16'h3458; D_miss = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        #1;
        check_all_zero("t5_async_rst");
        D_miss = 1'b0;
        flush(); clear_stats();
        tick();
        rst = 1'b0;
        wr_before = wr_cnt;
        force_valid = 1'b1;
        tick();
        chk("t5_stale_valid_1", {31'd0, write_data_array}, 32'd0);
        tick();
        chk("t5_stale_valid_2", {31'd0, write_data_array}, 32'd0);
        force_valid = 1'b0;
        tick();
        chk("t5_no_writes", wr_cnt - wr_before, 32'd0);

        // Test 6: D miss drops mid-fill, then valids while idle
        clear_stats();
        expect_fill(16'h0A00, 1'b0);
        D_addr = 16'h0A0C; D_miss = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        D_miss = 1'b0;
        run_fill(done_cnt + 1, 40);
        tick();
        wr_before = wr_cnt;
        force_valid = 1'b1;
        tick(); tick(); tick();
        force_valid = 1'b0;
        chk("t6_idle_valid_no_write", wr_cnt - wr_before, 32'd0);
        chk("t6_still_idle", {31'd0, fsm_busy}, 32'd0);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
